// File: rtl/demux2way32_router_pkg.sv
// Shared constants for the 2-way 32-bit demux router.
package demux_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/demux2way32_router_fifo_sync.sv
// Single-clock FIFO with registered head, async active-high reset.
// Pop is ignored when empty; push while full succeeds only alongside a pop.
module fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_MAX);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/demux2way32_router.sv
// 1-to-2 demux with a small FIFO per destination.
// Optional per-port accept counters under `DEMUX_COUNT_EN.
import demux_pkg::*;

module demux2way32_router #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_addr,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
`ifdef DEMUX_COUNT_EN
  output logic [WIDTH-1:0] out1_data,
  output logic [31:0]      count0,
  output logic [31:0]      count1
`else
  output logic [WIDTH-1:0] out1_data
`endif
);
  logic [1:0]            push, pop, full, empty, ordy;
  logic [1:0][WIDTH-1:0] rdata;

  assign ordy = {out1_ready, out0_ready};

  // A full FIFO can still take a word when its head leaves this cycle
  assign in_ready = !full[in_addr] || (!empty[in_addr] && ordy[in_addr]);

  for (genvar i = 0; i < 2; i++) begin : g_port
    assign push[i] = in_valid && in_ready && (in_addr == 1'(i));
    assign pop[i]  = ordy[i];

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (in_data),
      .rdata (rdata[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign out0_valid = !empty[PORT0];
  assign out1_valid = !empty[PORT1];
  assign out0_data  = rdata[PORT0];
  assign out1_data  = rdata[PORT1];

`ifdef DEMUX_COUNT_EN
  logic [31:0] cnt0, cnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push[PORT0]) cnt0 <= cnt0 + 32'd1;
      if (push[PORT1]) cnt1 <= cnt1 + 32'd1;
    end
  end

  assign count0 = cnt0;
  assign count1 = cnt1;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, pop[0] & 1'b0, PTR_W[0] & 1'b0};
endmodule

// File: tb/tb_demux2way32_router.sv
// Scoreboard bench for demux2way32_router: expected words queued on accept,
// compared on pop; direct checks for reset, latency, backpressure and full+pop.
`timescale 1ns/1ps
module tb_demux2way32_router;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_addr;
  logic [31:0] in_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [31:0] out0_data, out1_data;
`ifdef DEMUX_COUNT_EN
  logic [31:0] count0, count1;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q0[$], q1[$];
  bit rnd1 = 1'b0;

  always #5 clk = ~clk;

  demux2way32_router dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
`ifdef DEMUX_COUNT_EN
    .out1_data  (out1_data),
    .count0     (count0),
    .count1     (count1)
`else
    .out1_data  (out1_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: record accepts, compare pops
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        if (in_addr) q1.push_back(in_data);
        else         q0.push_back(in_data);
      end
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) check("out0_spurious", 32'(q0.size()), 32'd1);
        else                check("out0_data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("out1_spurious", 32'(q1.size()), 32'd1);
        else                check("out1_data", out1_data, q1.pop_front());
      end
    end
  end

  always @(posedge clk) if (rnd1) #1 out1_ready = 1'($urandom_range(0, 1));

  // Present a word at posedge+1 and hold until accepted; returns at posedge+1
  task automatic send(input logic a, input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1; in_addr = a; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin @(posedge clk); n++; end
    #1 check("drain_empty", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = 1'b0; in_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    #12;
    check("rst_v0", 32'(out0_valid), 32'd0);
    check("rst_v1", 32'(out1_valid), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Basic routing with one-cycle latency
    send(1'b0, 32'hAAAA0001);
    check("lat0_valid", 32'(out0_valid), 32'd1);
    check("lat0_data", out0_data, 32'hAAAA0001);
    check("lat0_noxdel", 32'(out1_valid), 32'd0);
    send(1'b1, 32'hBBBB0002);
    check("lat1_valid", 32'(out1_valid), 32'd1);
    check("lat1_data", out1_data, 32'hBBBB0002);
    drain();

    // Backpressure isolation
    @(posedge clk); #1;
    out0_ready = 1'b0;
    send(1'b0, 32'h20);
    send(1'b0, 32'h21);
    in_valid = 1'b1; in_addr = 1'b0; in_data = 32'h22;
    #1 check("bp_full_rdy", 32'(in_ready), 32'd0);
    in_addr = 1'b1; in_data = 32'h30;
    #1 check("bp_other_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_other_valid", 32'(out1_valid), 32'd1);
    check("bp_other_data", out1_data, 32'h30);
    out0_ready = 1'b1;
    drain();

    // Full FIFO accepts while its head is popped
    @(posedge clk); #1;
    out0_ready = 1'b0;
    send(1'b0, 32'h10);
    send(1'b0, 32'h11);
    in_valid = 1'b1; in_addr = 1'b0; in_data = 32'h12; out0_ready = 1'b1;
    #1 check("fullpop_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fullpop_head", out0_data, 32'h11);
    drain();

    // Wrap and order on port 1 with random consumer stalls
    rnd1 = 1'b1;
    for (int i = 0; i < 10; i++) send(1'b1, 32'(i));
    rnd1 = 1'b0;
    #1 out1_ready = 1'b1;
    drain();

    // Asynchronous reset with both FIFOs holding words
    @(posedge clk); #1;
    out0_ready = 1'b0; out1_ready = 1'b0;
    send(1'b0, 32'h40); send(1'b1, 32'h50); send(1'b0, 32'h41); send(1'b1, 32'h51);
    #1 reset = 1'b1;
    #1;
    check("arst_v0", 32'(out0_valid), 32'd0);
    check("arst_v1", 32'(out1_valid), 32'd0);
    q0.delete(); q1.delete();
    @(negedge clk) reset = 1'b0;
    #1 in_addr = 1'b0;
    #1 check("post_rst_rdy0", 32'(in_ready), 32'd1);
    in_addr = 1'b1;
    #1 check("post_rst_rdy1", 32'(in_ready), 32'd1);
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(posedge clk); #1;

`ifdef DEMUX_COUNT_EN
    for (int i = 0; i < 5; i++) send(1'b0, 32'h100 + 32'(i));
    for (int i = 0; i < 3; i++) send(1'b1, 32'h200 + 32'(i));
    check("count0", count0, 32'd5);
    check("count1", count1, 32'd3);
    force dut.cnt0 = 32'hFFFFFFFF;
    #1 release dut.cnt0;
    #1 check("count0_pre", count0, 32'hFFFFFFFF);
    @(posedge clk); #1;
    send(1'b0, 32'h300);
    check("count0_wrap", count0, 32'd0);
    check("count1_hold", count1, 32'd3);
`endif

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
